// File: rtl/lbm_frame_scheduler_if.sv
// Control bundle between the D2Q9 frame scheduler, the compute engine and the readout path.
// The stall_cycles member exists only when LBM_STALL_COUNT_EN is defined.
interface lbm_frame_scheduler_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   start;
    logic                   stop;
    logic                   step_done;
    logic                   readout_done;
    logic                   step_start;
    logic                   compute_bank;
    logic                   read_bank;
    logic                   frame_ready;
    logic                   reading;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] step_count;
    logic [COUNT_WIDTH-1:0] frame_count;
`ifdef LBM_STALL_COUNT_EN
    logic [31:0]            stall_cycles;

    // Scheduler side: consumes the pulses, drives the sequencing outputs.
    modport master (
        input  start, stop, step_done, readout_done,
        output step_start, compute_bank, read_bank, frame_ready, reading, busy,
               step_count, frame_count, stall_cycles
    );

    modport slave (
        output start, stop, step_done, readout_done,
        input  step_start, compute_bank, read_bank, frame_ready, reading, busy,
               step_count, frame_count, stall_cycles
    );
`else
    modport master (
        input  start, stop, step_done, readout_done,
        output step_start, compute_bank, read_bank, frame_ready, reading, busy,
               step_count, frame_count
    );

    modport slave (
        output start, stop, step_done, readout_done,
        input  step_start, compute_bank, read_bank, frame_ready, reading, busy,
               step_count, frame_count
    );
`endif
endinterface

// File: rtl/lbm_frame_scheduler.sv
// Ping-pong bank sequencer for the D2Q9 solver: launches sweeps, publishes frames, and
// stalls compute before it overwrites the bank being streamed out. Optional: LBM_STALL_COUNT_EN.
module lbm_frame_scheduler #(
    parameter int DEPTH           = 2500,
    parameter int STEPS_PER_FRAME = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_aresetn,
    lbm_frame_scheduler_if.master bus
);

    localparam int SIF_W = (STEPS_PER_FRAME < 2) ? 1 : $clog2(STEPS_PER_FRAME + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        COMPUTE,
        PUB_WAIT,
        DRAIN
    } state_t;

    if (DEPTH < 1 || STEPS_PER_FRAME < 1) begin : g_param_check
        $error("lbm_frame_scheduler: DEPTH and STEPS_PER_FRAME must both be >= 1");
    end

    state_t           state;
    logic [SIF_W-1:0] steps_in_frame;
    logic             stop_pending;

    logic             write_bank;
    logic             launch_stall;
    logic             reading_eff;
    logic             stop_eff;
    logic [SIF_W-1:0] sif_inc;
    logic             frame_boundary;

    assign write_bank     = ~bus.compute_bank;
    assign launch_stall   = bus.reading && (write_bank == bus.read_bank);
    // A readout finishing in the same cycle frees the bank before any publish decision.
    assign reading_eff    = bus.reading && !bus.readout_done;
    assign stop_eff       = stop_pending || bus.stop;
    assign sif_inc        = steps_in_frame + SIF_W'(1);
    assign frame_boundary = (sif_inc == SIF_W'(STEPS_PER_FRAME));

    // NOTE: async assert / sync release; every register, including the FSM state,
    // returns to its idle value the moment m00_axis_aresetn falls.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state            <= IDLE;
            steps_in_frame   <= '0;
            stop_pending     <= 1'b0;
            bus.step_start   <= 1'b0;
            bus.compute_bank <= 1'b0;
            bus.read_bank    <= 1'b0;
            bus.frame_ready  <= 1'b0;
            bus.reading      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.step_count   <= '0;
            bus.frame_count  <= '0;
        end else begin
            // NOTE: pulses default low here; a later non-blocking assignment in the
            // case below overrides this default within the same cycle.
            bus.step_start  <= 1'b0;
            bus.frame_ready <= 1'b0;

            if (bus.readout_done && bus.reading) begin
                bus.reading <= 1'b0;
            end
            if (state != IDLE && bus.stop) begin
                stop_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= LAUNCH;
                        bus.busy <= 1'b1;
                    end
                end

                LAUNCH: begin
                    if (!launch_stall) begin
                        bus.step_start <= 1'b1;
                        state          <= COMPUTE;
                    end
                end

                COMPUTE: begin
                    if (bus.step_done) begin
                        bus.compute_bank <= write_bank;
                        bus.step_count   <= bus.step_count + COUNT_WIDTH'(1);
                        if (!frame_boundary) begin
                            steps_in_frame <= sif_inc;
                            state          <= LAUNCH;
                        end else if (reading_eff) begin
                            steps_in_frame <= sif_inc;
                            state          <= PUB_WAIT;
                        end else begin
                            // The freshly written bank becomes the published frame.
                            bus.read_bank   <= write_bank;
                            bus.frame_ready <= 1'b1;
                            bus.reading     <= 1'b1;
                            bus.frame_count <= bus.frame_count + COUNT_WIDTH'(1);
                            steps_in_frame  <= '0;
                            state           <= stop_eff ? DRAIN : LAUNCH;
                        end
                    end
                end

                PUB_WAIT: begin
                    if (bus.readout_done) begin
                        bus.read_bank   <= bus.compute_bank;
                        bus.frame_ready <= 1'b1;
                        bus.reading     <= 1'b1;
                        bus.frame_count <= bus.frame_count + COUNT_WIDTH'(1);
                        steps_in_frame  <= '0;
                        state           <= stop_eff ? DRAIN : LAUNCH;
                    end
                end

                DRAIN: begin
                    if (!bus.reading || bus.readout_done) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        stop_pending <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef LBM_STALL_COUNT_EN
    logic stalled_now;

    assign stalled_now = (state == LAUNCH && launch_stall) ||
                         (state == PUB_WAIT && !bus.readout_done);

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            bus.stall_cycles <= '0;
        end else if (state == IDLE && bus.start) begin
            bus.stall_cycles <= '0;
        end else if (stalled_now && !(&bus.stall_cycles)) begin
            bus.stall_cycles <= bus.stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lbm_frame_scheduler.sv
// Directed bench for lbm_frame_scheduler: one instance per STEPS_PER_FRAME setting (1 and 2),
// shared clock and reset, hand-computed expectations at each step.
module tb_lbm_frame_scheduler;

    logic clk;
    logic rst_n;

    int n_pass;
    int n_total;

    lbm_frame_scheduler_if #(.COUNT_WIDTH(16)) bus1 ();
    lbm_frame_scheduler_if #(.COUNT_WIDTH(16)) bus2 ();

    lbm_frame_scheduler #(
        .DEPTH(2500), .STEPS_PER_FRAME(1), .COUNT_WIDTH(16)
    ) u_dut1 (
        .m00_axis_aclk   (clk),
        .m00_axis_aresetn(rst_n),
        .bus             (bus1)
    );

    lbm_frame_scheduler #(
        .DEPTH(2500), .STEPS_PER_FRAME(2), .COUNT_WIDTH(16)
    ) u_dut2 (
        .m00_axis_aclk   (clk),
        .m00_axis_aresetn(rst_n),
        .bus             (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs set here land on the next edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        {bus1.start, bus1.stop, bus1.step_done, bus1.readout_done} = '0;
        {bus2.start, bus2.stop, bus2.step_done, bus2.readout_done} = '0;

        tick(2);
        check("rst_step_start",   bus1.step_start,   0);
        check("rst_compute_bank", bus1.compute_bank, 0);
        check("rst_read_bank",    bus1.read_bank,    0);
        check("rst_frame_ready",  bus1.frame_ready,  0);
        check("rst_reading",      bus1.reading,      0);
        check("rst_busy",         bus1.busy,         0);
        check("rst_step_count",   bus1.step_count,   0);
        check("rst_frame_count",  bus1.frame_count,  0);
        rst_n = 1'b1;
        tick(2);

        // ---- DUT1 (1 sweep/frame): first frame ----
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("start_busy",       bus1.busy,       1);
        check("launch_no_pulse",  bus1.step_start, 0);
        tick();
        check("first_step_start", bus1.step_start, 1);
        tick(4);
        check("compute_no_frame", bus1.frame_ready, 0);
        bus1.step_done = 1'b1;
        tick();
        bus1.step_done = 1'b0;
        check("f1_frame_ready",   bus1.frame_ready,  1);
        check("f1_read_bank",     bus1.read_bank,    1);
        check("f1_compute_bank",  bus1.compute_bank, 1);
        check("f1_frame_count",   bus1.frame_count,  1);
        check("f1_step_count",    bus1.step_count,   1);
        check("f1_reading",       bus1.reading,      1);
        tick();
        check("s2_step_start",    bus1.step_start,  1);
        check("f1_pulse_width",   bus1.frame_ready, 0);

        // ---- second frame while first is still streaming -> PUB_WAIT ----
        tick(2);
        bus1.step_done = 1'b1;
        tick();
        bus1.step_done = 1'b0;
        check("pw_compute_bank",  bus1.compute_bank, 0);
        check("pw_no_frame",      bus1.frame_ready,  0);
        check("pw_step_count",    bus1.step_count,   2);
        check("pw_frame_count",   bus1.frame_count,  1);
        tick(2);
        check("pw_hold_frame",    bus1.frame_ready, 0);
        check("pw_hold_launch",   bus1.step_start,  0);
        bus1.readout_done = 1'b1;
        tick();
        bus1.readout_done = 1'b0;
        check("f2_frame_ready",   bus1.frame_ready, 1);
        check("f2_read_bank",     bus1.read_bank,   0);
        check("f2_frame_count",   bus1.frame_count, 2);
        check("f2_reading",       bus1.reading,     1);
        tick();
        check("s3_step_start",    bus1.step_start, 1);

        // ---- stop mid-sweep: sweep completes, one publish, DRAIN, IDLE ----
        bus1.stop = 1'b1;
        tick();
        bus1.stop = 1'b0;
        bus1.readout_done = 1'b1;
        tick();
        bus1.readout_done = 1'b0;
        check("stop_still_busy",  bus1.busy,    1);
        check("stop_rd_cleared",  bus1.reading, 0);
        bus1.step_done = 1'b1;
        tick();
        check("stop_frame_ready", bus1.frame_ready, 1);
        check("stop_frame_count", bus1.frame_count, 3);
        check("stop_step_count",  bus1.step_count,  3);
        tick();
        bus1.step_done = 1'b0;
        check("drain_no_launch",  bus1.step_start, 0);
        check("drain_busy",       bus1.busy,       1);
        check("drain_ign_step",   bus1.step_count, 3);
        bus1.readout_done = 1'b1;
        tick();
        bus1.readout_done = 1'b0;
        check("idle_busy",        bus1.busy,    0);
        check("idle_reading",     bus1.reading, 0);
        bus1.step_done = 1'b1;
        tick();
        bus1.step_done = 1'b0;
        check("idle_ign_step",    bus1.step_count, 3);
        check("idle_no_launch",   bus1.step_start, 0);

        // ---- restart; step_done and readout_done coincide at a frame boundary ----
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        check("rs_step_start",    bus1.step_start, 1);
        bus1.step_done = 1'b1;
        tick();
        bus1.step_done = 1'b0;
        check("rs_frame_count",   bus1.frame_count, 4);
        check("rs_read_bank",     bus1.read_bank,   0);
        tick();
        check("rs_step_start2",   bus1.step_start, 1);
        bus1.step_done    = 1'b1;
        bus1.readout_done = 1'b1;
        tick();
        bus1.step_done    = 1'b0;
        bus1.readout_done = 1'b0;
        check("sim_frame_ready",  bus1.frame_ready, 1);
        check("sim_reading",      bus1.reading,     1);
        check("sim_frame_count",  bus1.frame_count, 5);
        check("sim_read_bank",    bus1.read_bank,   1);
        tick();
        check("sim_no_pub_wait",  bus1.step_start, 1);

        // ---- DUT2 (2 sweeps/frame): launch stall on the streaming bank ----
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick();
        check("d2_step_start",    bus2.step_start, 1);
        bus2.step_done = 1'b1;
        tick();
        bus2.step_done = 1'b0;
        check("d2_mid_no_frame",  bus2.frame_ready,  0);
        check("d2_mid_bank",      bus2.compute_bank, 1);
        tick();
        bus2.step_done = 1'b1;
        tick();
        bus2.step_done = 1'b0;
        check("d2_frame_ready",   bus2.frame_ready,  1);
        check("d2_read_bank",     bus2.read_bank,    0);
        check("d2_compute_bank",  bus2.compute_bank, 0);
        tick();
        check("d2_launch_free",   bus2.step_start, 1);
        bus2.step_done = 1'b1;
        tick();
        bus2.step_done = 1'b0;
        check("d2_step_count",    bus2.step_count, 3);
        tick();
        check("d2_stall_0",       bus2.step_start, 0);
        tick();
        check("d2_stall_1",       bus2.step_start, 0);
        tick();
        check("d2_stall_2",       bus2.step_start, 0);
        bus2.readout_done = 1'b1;
        tick();
        bus2.readout_done = 1'b0;
        check("d2_stall_3",       bus2.step_start, 0);
        check("d2_rd_cleared",    bus2.reading,    0);
        tick();
        check("d2_released",      bus2.step_start, 1);
`ifdef LBM_STALL_COUNT_EN
        check("d2_stall_cycles",  bus2.stall_cycles, 4);
`endif

        // ---- asynchronous reset while DUT1 computes with a frame streaming ----
        check("pre_rst_reading",  bus1.reading, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_reading",      bus1.reading,      0);
        check("arst_busy",         bus1.busy,         0);
        check("arst_compute_bank", bus1.compute_bank, 0);
        check("arst_read_bank",    bus1.read_bank,    0);
        check("arst_step_count",   bus1.step_count,   0);
        check("arst_frame_count",  bus1.frame_count,  0);
        tick(2);
        rst_n = 1'b1;
        tick();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        check("post_step_start",   bus1.step_start, 1);
        bus1.step_done = 1'b1;
        tick();
        bus1.step_done = 1'b0;
        check("post_frame_ready",  bus1.frame_ready,  1);
        check("post_read_bank",    bus1.read_bank,    1);
        check("post_compute_bank", bus1.compute_bank, 1);
        check("post_step_count",   bus1.step_count,   1);
        check("post_frame_count",  bus1.frame_count,  1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
